// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Round-robin arbiter and sequencer that lets NREQ issuing units share one
// combinational 32-bit ALU. A request is accepted in IDLE, its opcode and
// operands are registered onto the ALU inputs, the ALU output is captured one
// cycle later (EXEC), and the result is returned tagged with the requester ID
// on a single response channel that honours backpressure (RESP).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. On the request side ready is produced combinationally from the
// valids and never depends on a transfer in the same cycle. On the response
// side rsp_valid stays high and all rsp_* outputs stay unchanged until the
// edge where rsp_ready is also high.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or 0)
//   req_ctrl/req_x/req_y     packed per-requester opcode and operands
//   alu_ctrl/alu_x/alu_y     registered opcode/operands to the shared ALU
//   alu_result, alu_v/z/s/c  ALU result and flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/result/flags/err  response payload, flags are {V,Z,S,C}
//   busy                     high whenever not IDLE
//   dbg_state                current FSM state (0 IDLE, 1 EXEC, 2 RESP)
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_ctrl,
  input  logic [32*NREQ-1:0] req_x,
  input  logic [32*NREQ-1:0] req_y,
  output logic [3:0]        alu_ctrl,
  output logic [31:0]       alu_x,
  output logic [31:0]       alu_y,
  input  logic [31:0]       alu_result,
  input  logic              alu_v,
  input  logic              alu_z,
  input  logic              alu_s,
  input  logic              alu_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;

  // Grant search: first valid requester at or above rr_ptr, with wrap.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   probe;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    probe     = '0;
    for (int k = 0; k < NREQ; k++) begin
      probe = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ)) begin
        probe = probe - (IDW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[probe[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = probe[IDW-1:0];
      end
    end
  end

  logic [NREQ-1:0] gnt_onehot;
  logic            grant;
  logic [IDW-1:0]  ptr_nxt;
  logic [3:0]      sel_ctrl;
  logic [31:0]     sel_x;
  logic [31:0]     sel_y;
  logic            capture;
  logic            ctrl_illegal;

  assign gnt_onehot = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
  // Reset masks ready so a request presented during reset is never accepted.
  assign req_ready  = (state == IDLE && !rst) ? gnt_onehot : '0;

  assign sel_ctrl = req_ctrl[int'(gnt_idx)*4 +: 4];
  assign sel_x    = req_x[int'(gnt_idx)*32 +: 32];
  assign sel_y    = req_y[int'(gnt_idx)*32 +: 32];

  assign ptr_nxt = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

  // The ALU holds its previous output for undefined codes, so those results
  // cannot be trusted and are replaced by zero with the error bit set.
  assign ctrl_illegal = (alu_ctrl == 4'h0) || (alu_ctrl > 4'hA);

  // Next-state and control
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      alu_ctrl   <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant) begin
        alu_ctrl <= sel_ctrl;
        alu_x    <= sel_x;
        alu_y    <= sel_y;
        cur_id   <= gnt_idx;
        rr_ptr   <= ptr_nxt;
      end
      if (capture) begin
        if (ctrl_illegal) begin
          rsp_result <= '0;
          rsp_flags  <= '0;
          rsp_err    <= 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_v, alu_z, alu_s, alu_c};
          rsp_err    <= 1'b0;
        end
      end
    end
  end

  assign rsp_id    = cur_id;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 1 + 4 + 32;  // {id, err, flags, result}

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_ctrl;
  logic [32*NREQ-1:0] req_x;
  logic [32*NREQ-1:0] req_y;
  logic [3:0]        alu_ctrl;
  logic [31:0]       alu_x, alu_y, alu_result;
  logic              alu_v, alu_z, alu_s, alu_c;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err, busy;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_x(req_x), .req_y(req_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_result(alu_result),
    .alu_v(alu_v), .alu_z(alu_z), .alu_s(alu_s), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference ALU ----------------
  // Returns {V,Z,S,C, result}. C is carry on ADD and borrow on SUB.
  function automatic logic [35:0] alu_model(input logic [3:0] c,
                                            input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic        v, cy;
    s = '0; r = '0; v = 1'b0; cy = 1'b0;
    case (c)
      4'h1: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; cy = s[32];
                  v = (x[31] == y[31]) && (r[31] != x[31]); end
      4'h2: begin r = x - y; cy = (x < y);
                  v = (x[31] != y[31]) && (r[31] != x[31]); end
      4'h3: r = x & y;
      4'h4: r = x | y;
      4'h5: r = x ^ y;
      4'h6: r = {31'b0, $signed(x) < $signed(y)};
      4'h7: r = {31'b0, x < y};
      4'h8: r = x << y[4:0];
      4'h9: r = x >> y[4:0];
      4'hA: r = $unsigned($signed(x) >>> y[4:0]);
      default: return {4'hF, 32'hDEADBEEF};  // stale garbage for undefined codes
    endcase
    return {v, (r == 32'd0), r[31], cy, r};
  endfunction

  function automatic logic [W-1:0] exp_word(input int id, input logic [3:0] c,
                                            input logic [31:0] x, input logic [31:0] y);
    if (c == 4'h0 || c > 4'hA) return {IDW'(id), 1'b1, 36'd0};
    return {IDW'(id), 1'b0, alu_model(c, x, y)};
  endfunction

  // Stand-in for the shared combinational ALU.
  always_comb begin
    {alu_v, alu_z, alu_s, alu_c, alu_result} = alu_model(alu_ctrl, alu_x, alu_y);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Push on every accepted request; pop on every accepted response.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(exp_word(i, req_ctrl[i*4 +: 4], req_x[i*32 +: 32], req_y[i*32 +: 32]));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: got response id=%0d with empty queue", rsp_id);
        end else begin
          chk("sb_rsp", 64'({rsp_id, rsp_err, rsp_flags, rsp_result}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input logic [3:0] c,
                           input logic [31:0] x, input logic [31:0] y);
    req_valid[id]        = 1'b1;
    req_ctrl[id*4 +: 4]  = c;
    req_x[id*32 +: 32]   = x;
    req_y[id*32 +: 32]   = y;
  endtask

  // Called on a negedge; returns on the negedge after the grant edge.
  task automatic wait_grant(input int id, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready[id]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_grant_timeout: got no req_ready for id %0d expected grant", name, id);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk); n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [3:0]  ctrl;
    logic [31:0] x, y, res;
    logic [3:0]  flg;
    logic        err;
  } vec_t;

  vec_t vecs[13];
  bit   ok;
  int   gid[6];
  int   gcyc[6];
  int   ng;
  logic [W-1:0] snap;

  initial begin
    vecs[0]  = '{0, 4'h1, 32'hFFFFFFFF, 32'd1,  32'h00000000, 4'b0101, 1'b0};
    vecs[1]  = '{2, 4'h2, 32'd5,        32'd7,  32'hFFFFFFFE, 4'b0011, 1'b0};
    vecs[2]  = '{1, 4'hF, 32'd3,        32'd4,  32'h00000000, 4'b0000, 1'b1};
    vecs[3]  = '{3, 4'h3, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 1'b0};
    vecs[4]  = '{0, 4'h5, 32'hA5A5,     32'hA5A5, 32'h0,       4'b0100, 1'b0};
    vecs[5]  = '{2, 4'h6, 32'hFFFFFFFF, 32'd1,  32'h00000001, 4'b0000, 1'b0};
    vecs[6]  = '{1, 4'h7, 32'hFFFFFFFF, 32'd1,  32'h00000000, 4'b0100, 1'b0};
    vecs[7]  = '{3, 4'h8, 32'd1,        32'd31, 32'h80000000, 4'b0010, 1'b0};
    vecs[8]  = '{0, 4'hA, 32'h80000000, 32'd4,  32'hF8000000, 4'b0010, 1'b0};
    vecs[9]  = '{2, 4'h0, 32'd7,        32'd7,  32'h00000000, 4'b0000, 1'b1};
    vecs[10] = '{1, 4'h4, 32'h0F00,     32'h00F0, 32'h00000FF0, 4'b0000, 1'b0};
    vecs[11] = '{3, 4'h9, 32'h80000000, 32'd31, 32'h00000001, 4'b0000, 1'b0};
    vecs[12] = '{0, 4'h1, 32'h7FFFFFFF, 32'd1,  32'h80000000, 4'b1010, 1'b0};

    // ---------------- reset ----------------
    rst = 1'b1; req_valid = '0; req_ctrl = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_alu", 64'({alu_ctrl, alu_x[11:0], alu_y[11:0]}), 64'd0);
    chk("reset_rsp", 64'({rsp_id, rsp_err, rsp_flags, rsp_result}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 13; i++) begin
      drive_req(vecs[i].id, vecs[i].ctrl, vecs[i].x, vecs[i].y);
      wait_grant(vecs[i].id, "vec", ok);
      req_valid = '0;
      if (ok) begin
        #1;
        chk("vec_exec_busy", 64'({busy, rsp_valid}), 64'b10);
        chk("vec_alu_in", 64'({alu_ctrl, alu_x}), 64'({vecs[i].ctrl, vecs[i].x}));
        @(negedge clk); #1;
        chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("vec_rsp", 64'({rsp_id, rsp_err, rsp_flags, rsp_result}),
            64'({IDW'(vecs[i].id), vecs[i].err, vecs[i].flg, vecs[i].res}));
        @(negedge clk); #1;
        chk("vec_back_idle", 64'({busy, rsp_valid}), 64'd0);
      end
      @(negedge clk);
    end
    drain("vec");

    // ---------------- backpressure ----------------
    rsp_ready = 1'b0;
    drive_req(2, 4'h5, 32'h1234, 32'hFFFF);
    wait_grant(2, "bp", ok);
    req_valid = '0;
    drive_req(3, 4'h1, 32'd1, 32'd1);  // competing request must stay blocked
    @(negedge clk); #1;
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    snap = {rsp_id, rsp_err, rsp_flags, rsp_result};
    chk("bp_rsp_value", 64'(snap), 64'({2'd2, 1'b0, 4'b0000, 32'h0000EDCB}));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}), 64'({1'b1, snap}));
      chk("bp_ready_zero", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_idle", 64'({dbg_state, busy, rsp_valid}), 64'd0);
    drain("bp");

    // ---------------- round-robin ----------------
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) drive_req(i, 4'h1, 32'(i * 100), 32'(i));
    ng = 0;
    for (int n = 0; n < 40 && ng < 6; n++) begin
      #1;
      chk("rr_onehot0", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && ng < 6) begin gid[ng] = i; gcyc[ng] = cyc; ng++; end
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_grant_count", 64'(ng), 64'd6);
    for (int i = 0; i < ng; i++) begin
      chk("rr_order", 64'(gid[i]), 64'(i % NREQ));
      if (i > 0) chk("rr_interval", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    end
    drain("rr");

    // ---------------- reset in EXEC ----------------
    drive_req(0, 4'h1, 32'd2, 32'd3);
    wait_grant(0, "rst", ok);
    req_valid = '0;
    #1;
    chk("rst_in_exec", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    exp_q.delete();  // the in-flight operation is discarded
    drive_req(1, 4'h3, 32'h0000F0F0, 32'h0000FF00);
    drive_req(3, 4'h2, 32'd9, 32'd4);
    @(negedge clk); #1;
    chk("rst_ready_masked", 64'(req_ready), 64'd0);
    chk("rst_outputs_zero", 64'({rsp_valid, busy, rsp_result, rsp_flags, rsp_err}), 64'd0);
    chk("rst_alu_zero", 64'({alu_ctrl, alu_x[27:0]}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_first_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst_no_stale_rsp", 64'(rsp_valid), 64'd0);
    drain("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one combinational `ThirtyTwoBitALU` instance among `NREQ` requesters. It accepts operation requests over valid/ready handshakes and drives registered operands and opcode into the ALU. It captures the ALU result and flags one cycle later and returns them, tagged with the requester ID, over a single response channel with backpressure. It sits between the issuing units and the shared ALU, which is instantiated alongside it at the same level.

## Interface
- `NREQ`, default 4, number of requesters (2..8).
- `IDW`, default 2, requester ID width; must equal `clog2(NREQ)`.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `req_valid`, in, `NREQ`, per-requester request valid.
- `req_ready`, out, `NREQ`, per-requester accept; one-hot or zero.
- `req_ctrl`, in, `4*NREQ`, opcodes; requester i uses bits `[4i+3:4i]`.
- `req_x`, in, `32*NREQ`, operand x per requester.
- `req_y`, in, `32*NREQ`, operand y per requester.
- `alu_ctrl`, out, 4, registered opcode to the ALU.
- `alu_x`, out, 32, registered operand x to the ALU.
- `alu_y`, out, 32, registered operand y to the ALU.
- `alu_result`, in, 32, ALU result.
- `alu_v`, `alu_z`, `alu_s`, `alu_c`, in, 1 each, ALU flags.
- `rsp_valid`, out, 1, response valid.
- `rsp_ready`, in, 1, response accept.
- `rsp_id`, out, `IDW`, index of the requester that owns the response.
- `rsp_result`, out, 32, captured result.
- `rsp_flags`, out, 4, captured flags `{V,Z,S,C}`.
- `rsp_err`, out, 1, opcode was illegal.
- `busy`, out, 1, high whenever the state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` is asserted combinationally for exactly one requester: the first set `req_valid` bit searching upward from `rr_ptr`, with wrap.
  - On handshake (`req_valid[i] & req_ready[i]`): latch `req_ctrl[i]`/`req_x[i]`/`req_y[i]` into `alu_ctrl`/`alu_x`/`alu_y`, latch ID i, set `rr_ptr` to (i+1) mod `NREQ`, go to EXEC.
- **EXEC** (exactly one cycle)
  - The ALU inputs are stable for this cycle.
  - At the end of the cycle, capture `alu_result` into `rsp_result` and `{alu_v,alu_z,alu_s,alu_c}` into `rsp_flags`; go to RESP.
- **RESP**
  - `rsp_valid` is 1.
  - All response outputs are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- `req_ready` is all-zero in EXEC and RESP. There is no request pipelining.
- Legal opcodes: 4'h1..4'hA (ADD, SUB, AND, OR, XOR, SLT, ULT, LSL, LSR, ASR).
- Illegal opcode (0, B..F):
  - Accepted and sequenced with normal timing; `alu_ctrl` carries the code unchanged.
  - At capture, force `rsp_result`=0, `rsp_flags`=0, `rsp_err`=1.
  - This is required because the ALU holds its previous result for undefined codes.
- `rsp_err`=0 for legal opcodes.
- Requesters with `req_valid` low are skipped with no penalty. The pointer advances only on a grant.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.

## Timing
- Reset (`rst`=1 at an edge):
  - State becomes IDLE and `rr_ptr` becomes 0.
  - `alu_ctrl`/`alu_x`/`alu_y`, `rsp_*`, and `busy` all become 0.
  - `req_ready` is forced to 0 while `rst` is high.
- Reset mid-operation (EXEC or RESP) discards the operation; no response is ever produced for it.
- Latency: handshake at edge T, `alu_*` valid after T, result captured at T+1, `rsp_valid` high after T+1.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with immediate `rsp_ready`).
- `rsp_ready` high before `rsp_valid` has no effect.
- A requester may drop `req_valid` without a handshake; no state change results.
- `rst` asserted in the same cycle as a handshake: reset wins and the request is not accepted.

## Test plan
- **ADD carry:** req0 ADD x=32'hFFFFFFFF y=1, `rsp_ready`=1 -> `rsp_valid` 2 cycles after handshake, `rsp_id`=0, result 0, `rsp_flags`=4'b0101, `rsp_err`=0.
- **SUB borrow:** req2 SUB x=5 y=7 -> result 32'hFFFFFFFE, `rsp_flags`=4'b0011, `rsp_id`=2.
- **Round-robin:** all 4 `req_valid` held high, `rsp_ready`=1 -> grant order 0,1,2,3,0,1 with one grant every 3 cycles; `req_ready` is never more than one-hot.
- **Backpressure:** `rsp_ready` held low 5 cycles in RESP -> `rsp_*` stable, `req_ready`=0 throughout; `rsp_ready`=1 -> IDLE next cycle.
- **Illegal opcode:** req1 ctrl=4'hF x=3 y=4 -> `rsp_result`=0, `rsp_flags`=0, `rsp_err`=1; a following legal AND 32'hF0F0 & 32'hFF00 returns 32'hF000 with `rsp_err`=0.
- **Reset in EXEC:** `rst` pulsed in EXEC -> no `rsp_valid`, all outputs 0; with req1 and req3 valid afterwards, req1 is granted first (`rr_ptr`=0).
